// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: operation codes, FSM states and
// the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 24;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FINISH = 2'b10,
        S_DONE   = 2'b11
    } state_t;

endpackage

// File: rtl/ALU_1bit.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
// The adder carry is produced for every operation.
module ALU_1bit (
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff = a ^ ainvert;
    assign b_eff = b ^ binvert;
    assign sum   = a_eff ^ b_eff ^ cin;
    assign cout  = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));

    always_comb begin
        result = 1'b0;
        case (operation)
            2'b00:   result = a_eff & b_eff;
            2'b01:   result = a_eff | b_eff;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu24.sv
// Bit-serial ALU: one ALU_1bit slice iterated LSB-first over WIDTH cycles,
// followed by a flag/SLT fix-up cycle and a one-cycle Done pulse.
module serial_alu24
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             AInvert,
    input  logic             BInvert,
    input  logic             CarryIn,
    input  logic [1:0]       Operation,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic             busy_next;
    logic             done_next;

    logic [CW-1:0]    cnt_reg;
    logic             last_bit;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] result_sh_reg;
    logic             ainv_reg;
    logic             binv_reg;
    logic [1:0]       op_reg;
    logic             carry_reg;
    logic             msb_cin_reg;
    logic             msb_sum_reg;

    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic [1:0]       slice_op;
    logic             slice_res;
    logic             slice_cout;
    logic             overflow_raw;
    logic [WIDTH-1:0] result_next;

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    // SLT needs the subtraction itself; the less-than bit is fixed up afterwards.
    assign slice_op = (op_reg == OP_SLT) ? OP_ADD : op_reg;

    ALU_1bit u_slice (
        .a         (a_sh_reg[0]),
        .b         (b_sh_reg[0]),
        .ainvert   (ainv_reg),
        .binvert   (binv_reg),
        .cin       (carry_reg),
        .less      (1'b0),
        .operation (slice_op),
        .result    (slice_res),
        .cout      (slice_cout)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy_next = 1'b1;
                if (last_bit) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                busy_next  = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done_next = 1'b1;
                if (Start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Signed less-than is the true sign of A-B: sum MSB corrected by overflow.
    always_comb begin
        overflow_raw = msb_cin_reg ^ carry_reg;
        result_next  = result_sh_reg;
        if (op_reg == OP_SLT) begin
            result_next    = '0;
            result_next[0] = msb_sum_reg ^ overflow_raw;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt_reg       <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            result_sh_reg <= '0;
            ainv_reg      <= 1'b0;
            binv_reg      <= 1'b0;
            op_reg        <= OP_AND;
            carry_reg     <= 1'b0;
            msb_cin_reg   <= 1'b0;
            msb_sum_reg   <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= A;
            b_sh_reg  <= B;
            ainv_reg  <= AInvert;
            binv_reg  <= BInvert;
            op_reg    <= Operation;
            carry_reg <= CarryIn;
            cnt_reg   <= '0;
        end else if (state_reg == S_RUN) begin
            a_sh_reg      <= a_sh_reg >> 1;
            b_sh_reg      <= b_sh_reg >> 1;
            result_sh_reg <= {slice_res, result_sh_reg[WIDTH-1:1]};
            carry_reg     <= slice_cout;
            cnt_reg       <= cnt_reg + CW'(1);
            if (last_bit) begin
                msb_cin_reg <= carry_reg;
                msb_sum_reg <= slice_res;
            end
        end else if (state_reg == S_FINISH) begin
            result_reg    <= result_next;
            carry_out_reg <= carry_reg;
            overflow_reg  <= op_reg[1] & overflow_raw;
            zero_reg      <= (result_next == '0);
        end
    end

    assign Busy     = busy_next;
    assign Done     = done_next;
    assign Result   = result_reg;
    assign CarryOut = carry_out_reg;
    assign Overflow = overflow_reg;
    assign Zero     = zero_reg;

endmodule

// File: doc/serial_alu24.md
Name: serial_alu24

Overview:
- Bit-serial 24-bit ALU. It reuses a single 1-bit ALU slice over WIDTH cycles, LSB first, with a Start/Done handshake.
- It is the sequential consumer of the 1-bit slice: the area-minimal alternative to the 24-slice ripple ALU in the 24-bit CPU datapath.
- It supports AND, OR, NOR (via inverts), ADD, SUB and SLT, and reports CarryOut, Overflow and Zero.

Parameters:
- WIDTH, 24, operand/result width in bits; minimum 2.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- Clock  in  1  rising-edge clock; the only clock.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  request pulse; sampled only in IDLE or DONE.
- A  in  WIDTH  operand A; captured when Start is accepted.
- B  in  WIDTH  operand B; captured when Start is accepted.
- AInvert  in  1  invert A bits; captured with Start.
- BInvert  in  1  invert B bits; captured with Start.
- CarryIn  in  1  carry into bit 0 (1 for SUB/SLT); captured with Start.
- Operation  in  2  00 AND, 01 OR, 10 ADD, 11 SLT; captured with Start.
- Busy  out  1  high in RUN and FINISH.
- Done  out  1  one-cycle pulse; Result and flags are valid.
- Result  out  WIDTH  registered result; held until the next accepted Start.
- CarryOut  out  1  carry out of bit WIDTH-1.
- Overflow  out  1  signed overflow; ADD/SLT only, else 0.
- Zero  out  1  Result == 0.

Behaviour:
- Reset (asynchronous, ResetN=0):
  - State goes to IDLE; counter, shift registers and carry register clear to 0.
  - All outputs are 0: Busy=0, Done=0, Result=0, CarryOut=0, Overflow=0, Zero=0.
  - Reset asserted mid-operation aborts the operation; no Done is produced.
- States: IDLE, RUN, FINISH, DONE.
  - IDLE -> RUN on Start. Latch A, B, control fields; carry register <= CarryIn; counter <= 0.
  - RUN: each cycle the slice takes A_sh[0], B_sh[0], the latched inverts, the carry register and Less=0.
    - Slice Operation = latched Operation, except SLT, which runs the slice as ADD (10).
    - The slice result bit shifts into Result_sh at the MSB; A_sh and B_sh shift right.
    - Carry register <= slice COUT. Counter increments.
  - RUN at counter == WIDTH-1: also capture msb_cin (the carry into the MSB) and msb_sum (the slice result bit); go to FINISH.
  - FINISH, one cycle:
    - Overflow = msb_cin ^ final carry (ADD/SLT), else 0.
    - For SLT: Result = {WIDTH-1 zeros, msb_sum ^ overflow_raw}. Otherwise Result = Result_sh.
    - CarryOut = final carry. Zero computed on the final Result. Go to DONE.
  - DONE: Done=1, Busy=0 for exactly one cycle.
    - Start here is accepted (back-to-back): go to RUN with new operands. Otherwise go to IDLE.
- Latency: Start sampled at edge T; Done high during cycle T+WIDTH+2 (26 cycles for WIDTH=24) for every operation.
- Start is ignored while Busy=1; operands on A/B may change freely after capture.
- Result and flags change only in FINISH; they are stable from Done until FINISH of the next operation.
- NOR = AInvert=1, BInvert=1, Operation=00. SUB = BInvert=1, CarryIn=1, Operation=10.

Decomposition:
- Shared package alu_pkg holds:
  - Operation encodings OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SLT=2'b11.
  - FSM state encoding S_IDLE, S_RUN, S_FINISH, S_DONE.
  - Default width ALU_WIDTH=24.
- One sub-module: the existing 1-bit slice ALU_1bit, instantiated once.
- Everything else (FSM, counter, shift registers, flag logic) is inline.

Test Plan:
- ADD A=0x000001, B=0xFFFFFF, CarryIn=0 -> Result=0x000000, CarryOut=1, Zero=1, Overflow=0. Done exactly 26 cycles after the Start edge; Busy high for the 25 cycles before.
- SUB A=0x7FFFFF, B=0xFFFFFF (BInvert=1, CarryIn=1) -> Result=0x800000, Overflow=1, CarryOut=0, Zero=0.
- SLT A=0xFFFFFE, B=0x000003 -> Result=0x000001. SLT A=0x800000, B=0x000001 (overflow case) -> Result=0x000001, Overflow=1. SLT A=0x000005, B=0x000005 -> Result=0x000000, Zero=1.
- NOR A=0x0F0F0F, B=0x00FF00 -> Result=0xF000F0. OR of the same operands -> 0x0FFF0F. AND of the same operands -> 0x000F00.
- Start pulsed at cycle 5 of a run with different operands -> ignored; the first result is unaffected. A Start held during the DONE cycle -> new operation accepted, next Done 26 cycles later.
- ResetN driven low at cycle 10 of a run -> all outputs 0 immediately (asynchronous); no Done. A fresh Start after release completes normally.
